tdm_demux_4_to_1: RTL

- Receive end of a 4-slot time-division link; the transmit end is a 4:1 mux whose select cycles 0..3.
- Takes one multiplexed sample stream plus a slot-0 sync marker and recovers four parallel channel samples.
- Presents a complete frame only after all four slots arrive, with a one-cycle frame strobe.
- Tracks alignment with a hunt/lock state machine and flags sync errors.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_slot_ctrl.sv | 99 +++++++++
 rtl/tdm_demux_4_to_1.sv | 81 ++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 4-slot TDM receive path.
// Slot geometry, lock state encoding and miss-counter width.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int MISS_W    = 3;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctrl.sv
// Slot sequencing and hunt/lock alignment for the TDM demux.
// Produces per-slot write enables, frame completion and error pulses.
module tdm_slot_ctrl
  import tdm_pkg::*;
#(
  parameter int MISS_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic                 sync,
  output logic [SLOT_W-1:0]    sel,
  output logic                 locked,
  output logic [NUM_SLOTS-1:0] we,
  output logic                 frame_done,
  output logic                 drop,
  output logic                 sync_err
);

  localparam logic [MISS_W-1:0] MMAX = MISS_W'(MISS_MAX);

  state_t            state, state_n;
  logic [SLOT_W-1:0] sel_n;
  logic [MISS_W-1:0] miss, miss_n, miss_inc;
  logic              err_n;

  assign miss_inc = miss + 3'd1;
  assign locked   = (state == LOCK);

  // State, slot index, miss count and registered error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      sel      <= '0;
      miss     <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      miss     <= miss_n;
      sync_err <= err_n;
    end
  end

  // Next-state decode of each valid beat
  always_comb begin
    state_n    = state;
    sel_n      = sel;
    miss_n     = miss;
    we         = '0;
    frame_done = 1'b0;
    drop       = 1'b0;
    err_n      = 1'b0;
    if (din_valid) begin
      if (state == HUNT) begin
        if (sync) begin
          we[0]   = 1'b1;
          sel_n   = 2'd1;
          miss_n  = '0;
          state_n = LOCK;
        end
      end else begin
        unique case (1'b1)
          (sel != 2'd0) && sync: begin
            err_n  = 1'b1;
            drop   = 1'b1;
            we[0]  = 1'b1;
            sel_n  = 2'd1;
            miss_n = '0;
          end
          (sel == 2'd0) && sync: begin
            we[0]  = 1'b1;
            sel_n  = 2'd1;
            miss_n = '0;
          end
          (sel == 2'd0) && !sync: begin
            if (miss_inc >= MMAX) begin
              state_n = HUNT;
              sel_n   = 2'd0;
              miss_n  = '0;
              err_n   = 1'b1;
              drop    = 1'b1;
            end else begin
              miss_n = miss_inc;
              we[0]  = 1'b1;
              sel_n  = 2'd1;
            end
          end
          default: begin
            we[sel]    = 1'b1;
            sel_n      = sel + 2'd1;
            frame_done = (sel == 2'd3);
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/tdm_demux_4_to_1.sv
// Receive end of a 4-slot TDM link.
// Collects slots into shadows and presents whole frames with a strobe.
module tdm_demux_4_to_1
  import tdm_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  logic [NUM_SLOTS-1:0] we;
  logic                 frame_done;
  logic                 drop;
  logic [WIDTH-1:0]     sh0, sh1, sh2;

  tdm_slot_ctrl #(
    .MISS_MAX(MISS_MAX)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .sync      (sync),
    .sel       (sel),
    .locked    (locked),
    .we        (we),
    .frame_done(frame_done),
    .drop      (drop),
    .sync_err  (sync_err)
  );

  // Shadow capture of slots 0..2; a dropped frame clears its tail
  always_ff @(posedge clk) begin
    if (rst) begin
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
    end else begin
      if (we[0]) sh0 <= din;
      if (drop) begin
        sh1 <= '0;
        sh2 <= '0;
      end else begin
        if (we[1]) sh1 <= din;
        if (we[2]) sh2 <= din;
      end
    end
  end

  // Frame commit: slot 3 goes straight to o3 with the shadows
  always_ff @(posedge clk) begin
    if (rst) begin
      o0          <= '0;
      o1          <= '0;
      o2          <= '0;
      o3          <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        o0 <= sh0;
        o1 <= sh1;
        o2 <= sh2;
      end
      if (we[3]) o3 <= din;
    end
  end

endmodule
